// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline hazard controller signal bundle
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        ex_memread;
    logic [4:0]  ex_wraddr;
    logic        ex_branch_taken;
    logic [31:0] ex_target;
    logic        ex_eret;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_pc;
    logic        exc_req;
    logic        en_pc;
    logic        en_ifid;
    logic        en_idex;
    logic        en_exmem;
    logic        en_memwb;
    logic        flush_ifid;
    logic        flush_idex;
    logic        flush_exmem;
    logic        flush_memwb;
    logic [1:0]  pc_sel;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic        bus_err;
    logic        busy;

    // Controller side: pipeline status in, stage controls out.
    modport slave (
        input  id_rs, id_rt, ex_memread, ex_wraddr, ex_branch_taken, ex_target,
               ex_eret, mem_req, mem_ack, mem_pc, exc_req,
        output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, flush_exmem, flush_memwb,
               pc_sel, redirect_pc, epc, bus_err, busy
    );

    // Pipeline side: drives status, consumes controls.
    modport master (
        output id_rs, id_rt, ex_memread, ex_wraddr, ex_branch_taken, ex_target,
               ex_eret, mem_req, mem_ack, mem_pc, exc_req,
        input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, flush_exmem, flush_memwb,
               pc_sel, redirect_pc, epc, bus_err, busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hold/flush sequencer with EPC and PC redirect
module pipe_hazard_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h8000_0180,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT - 1);

    state_t      state;
    state_t      nextState;
    logic [7:0]  waitCnt;
    logic [7:0]  nextCnt;
    logic [31:0] epcReg;

    logic timeout;
    logic excEvent;
    logic memStall;
    logic eretEvent;
    logic branchEvent;
    logic loadUse;

    // Classify this cycle's single winning event in priority order.
    always_comb begin
        timeout     = (state == MEMWAIT) && (waitCnt == TIMEOUT_CNT) && !bus.mem_ack;
        excEvent    = bus.exc_req || timeout;
        memStall    = !excEvent && !bus.mem_ack && ((state == MEMWAIT) || bus.mem_req);
        eretEvent   = !excEvent && !memStall && bus.ex_eret;
        branchEvent = !excEvent && !memStall && !eretEvent && bus.ex_branch_taken;
        loadUse     = !excEvent && !memStall && !eretEvent && !branchEvent &&
                      bus.ex_memread && (bus.ex_wraddr != 5'd0) &&
                      ((bus.ex_wraddr == bus.id_rs) || (bus.ex_wraddr == bus.id_rt));
    end

    // State, wait counter and EPC registers; EPC captures only on an exception edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            waitCnt <= 8'd0;
            epcReg  <= 32'd0;
        end else begin
            state   <= nextState;
            waitCnt <= nextCnt;
            if (excEvent) begin
                epcReg <= bus.mem_pc;
            end
        end
    end

    // Next state: a stall keeps counting, anything else returns to RUN with a cleared count.
    always_comb begin
        nextState = RUN;
        nextCnt   = 8'd0;
        if (memStall) begin
            nextState = MEMWAIT;
            nextCnt   = (state == RUN) ? 8'd1 : waitCnt + 8'd1;
        end
    end

    // Stage enables, flushes and PC redirect decoded from the winning event.
    always_comb begin
        bus.en_pc       = 1'b1;
        bus.en_ifid     = 1'b1;
        bus.en_idex     = 1'b1;
        bus.en_exmem    = 1'b1;
        bus.en_memwb    = 1'b1;
        bus.flush_ifid  = 1'b0;
        bus.flush_idex  = 1'b0;
        bus.flush_exmem = 1'b0;
        bus.flush_memwb = 1'b0;
        bus.pc_sel      = 2'd0;
        bus.redirect_pc = 32'd0;
        bus.bus_err     = 1'b0;
        bus.busy        = (state == MEMWAIT);
        bus.epc         = epcReg;
        if (reset) begin
            bus.en_pc       = 1'b0;
            bus.en_ifid     = 1'b0;
            bus.en_idex     = 1'b0;
            bus.en_exmem    = 1'b0;
            bus.en_memwb    = 1'b0;
            bus.flush_ifid  = 1'b1;
            bus.flush_idex  = 1'b1;
            bus.flush_exmem = 1'b1;
            bus.flush_memwb = 1'b1;
            bus.busy        = 1'b0;
        end else if (excEvent) begin
            // The faulting instruction in MEM is bubbled so it never writes back.
            bus.flush_ifid  = 1'b1;
            bus.flush_idex  = 1'b1;
            bus.flush_exmem = 1'b1;
            bus.flush_memwb = 1'b1;
            bus.pc_sel      = 2'd2;
            bus.redirect_pc = EXC_VECTOR;
            bus.bus_err     = timeout;
        end else if (memStall) begin
            // Freeze everything upstream of MEM; WB keeps draining with bubbles.
            bus.en_pc       = 1'b0;
            bus.en_ifid     = 1'b0;
            bus.en_idex     = 1'b0;
            bus.en_exmem    = 1'b0;
            bus.flush_memwb = 1'b1;
        end else if (eretEvent) begin
            bus.flush_ifid  = 1'b1;
            bus.flush_idex  = 1'b1;
            bus.pc_sel      = 2'd3;
            bus.redirect_pc = epcReg;
        end else if (branchEvent) begin
            bus.flush_ifid  = 1'b1;
            bus.flush_idex  = 1'b1;
            bus.pc_sel      = 2'd1;
            bus.redirect_pc = bus.ex_target;
        end else if (loadUse) begin
            bus.en_pc       = 1'b0;
            bus.en_ifid     = 1'b0;
            bus.flush_idex  = 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam logic [31:0] VEC = 32'h8000_0180;
    localparam int          TO  = 16;

    typedef struct packed {
        logic [4:0]  en;
        logic [3:0]  fl;
        logic [1:0]  sel;
        logic [31:0] rpc;
        logic        berr;
        logic        busy;
    } outs_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    int          mWaitCycles;
    logic [31:0] mEpc;

    pipe_hazard_ctrl_if hif();

    pipe_hazard_ctrl #(.EXC_VECTOR(VEC), .MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t dutOut();
        outs_t o;
        o.en   = {hif.en_pc, hif.en_ifid, hif.en_idex, hif.en_exmem, hif.en_memwb};
        o.fl   = {hif.flush_ifid, hif.flush_idex, hif.flush_exmem, hif.flush_memwb};
        o.sel  = hif.pc_sel;
        o.rpc  = hif.redirect_pc;
        o.berr = hif.bus_err;
        o.busy = hif.busy;
        return o;
    endfunction

    function automatic outs_t resetOut();
        outs_t o;
        o = '{en: 5'h00, fl: 4'hf, sel: 2'd0, rpc: 32'd0, berr: 1'b0, busy: 1'b0};
        return o;
    endfunction

    // Behavioural model: mWaitCycles = stalled cycles already spent on the current access.
    function automatic logic mStalled();
        return !hif.mem_ack && ((mWaitCycles > 0) || hif.mem_req);
    endfunction

    function automatic logic mTimeout();
        return mStalled() && (mWaitCycles + 1 == TO);
    endfunction

    function automatic outs_t modelOut();
        outs_t o;
        logic  lu;
        o = '{en: 5'h1f, fl: 4'h0, sel: 2'd0, rpc: 32'd0, berr: 1'b0, busy: 1'b0};
        if (reset) return resetOut();
        o.busy = (mWaitCycles > 0);
        lu = hif.ex_memread && (hif.ex_wraddr != 0) &&
             (hif.ex_wraddr == hif.id_rs || hif.ex_wraddr == hif.id_rt);
        if (hif.exc_req || mTimeout()) begin
            o.fl = 4'hf; o.sel = 2'd2; o.rpc = VEC; o.berr = mTimeout();
        end else if (mStalled()) begin
            o.en = 5'b00001; o.fl = 4'b0001;
        end else if (hif.ex_eret) begin
            o.fl = 4'b1100; o.sel = 2'd3; o.rpc = mEpc;
        end else if (hif.ex_branch_taken) begin
            o.fl = 4'b1100; o.sel = 2'd1; o.rpc = hif.ex_target;
        end else if (lu) begin
            o.en = 5'b00111; o.fl = 4'b0100;
        end
        return o;
    endfunction

    // Advance the model with the current inputs, then cross the clock edge.
    task automatic advance();
        logic exc;
        logic st;
        exc = hif.exc_req || mTimeout();
        st  = mStalled();
        if (exc) mEpc = hif.mem_pc;
        mWaitCycles = (exc || !st) ? 0 : mWaitCycles + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        hif.id_rs = 0; hif.id_rt = 0; hif.ex_memread = 0; hif.ex_wraddr = 0;
        hif.ex_branch_taken = 0; hif.ex_target = 0; hif.ex_eret = 0;
        hif.mem_req = 0; hif.mem_ack = 0; hif.mem_pc = 0; hif.exc_req = 0;
    endtask

    task automatic test_reset();
        outs_t got;
        #2;
        got = dutOut();
        checks++;
        if (got !== resetOut()) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", got, resetOut());
        end
        checks++;
        if (hif.epc !== 32'd0) begin
            errors++; $display("FAIL reset_epc: got %h expected 0", hif.epc);
        end
        reset = 1'b0;
        mWaitCycles = 0;
        mEpc = 32'd0;
        #1;
        got = dutOut();
        checks++;
        if (got !== modelOut()) begin
            errors++; $display("FAIL idle_after_reset: got %h expected %h", got, modelOut());
        end
        advance();
    endtask

    task automatic test_load_use();
        clearIn();
        hif.ex_memread = 1; hif.ex_wraddr = 5; hif.id_rt = 5; hif.id_rs = 7;
        #2;
        checks++;
        if ({hif.en_pc, hif.en_ifid, hif.flush_idex, hif.en_idex} !== 4'b0011) begin
            errors++; $display("FAIL load_use_stall: got %b expected 0011",
                {hif.en_pc, hif.en_ifid, hif.flush_idex, hif.en_idex});
        end
        advance();
        hif.ex_wraddr = 0; hif.id_rt = 0;
        #2;
        checks++;
        if ({hif.en_pc, hif.en_ifid, hif.flush_idex} !== 3'b110) begin
            errors++; $display("FAIL load_use_r0: got %b expected 110",
                {hif.en_pc, hif.en_ifid, hif.flush_idex});
        end
        advance();
        clearIn();
    endtask

    task automatic test_branch();
        hif.ex_branch_taken = 1; hif.ex_target = 32'h8000_0040;
        #2;
        checks++;
        if ({hif.pc_sel, hif.redirect_pc, hif.flush_ifid, hif.flush_idex} !== {2'd1, 32'h8000_0040, 2'b11}) begin
            errors++; $display("FAIL branch_redirect: got sel=%0d pc=%h fl=%b%b expected sel=1 pc=80000040 fl=11",
                hif.pc_sel, hif.redirect_pc, hif.flush_ifid, hif.flush_idex);
        end
        advance();
        hif.ex_memread = 1; hif.ex_wraddr = 9; hif.id_rs = 9;
        #2;
        checks++;
        if ({hif.en_pc, hif.en_ifid, hif.pc_sel, hif.redirect_pc} !== {2'b11, 2'd1, 32'h8000_0040}) begin
            errors++; $display("FAIL branch_over_load_use: got en=%b%b sel=%0d pc=%h expected en=11 sel=1 pc=80000040",
                hif.en_pc, hif.en_ifid, hif.pc_sel, hif.redirect_pc);
        end
        advance();
        clearIn();
    endtask

    task automatic test_mem_wait();
        hif.mem_req = 1;
        for (int i = 1; i <= 4; i++) begin
            hif.mem_ack = (i == 4);
            #2;
            checks++;
            if (i < 4) begin
                if ({hif.busy, hif.en_pc, hif.en_exmem, hif.en_memwb, hif.flush_memwb} !== {(i > 1), 4'b0011}) begin
                    errors++; $display("FAIL mem_wait_cycle%0d: got busy/en_pc/en_exmem/en_memwb/fl_memwb=%b expected %b",
                        i, {hif.busy, hif.en_pc, hif.en_exmem, hif.en_memwb, hif.flush_memwb}, {(i > 1), 4'b0011});
                end
            end else begin
                if ({hif.busy, hif.en_pc, hif.en_exmem, hif.en_memwb, hif.flush_memwb} !== 5'b11110) begin
                    errors++; $display("FAIL mem_ack_cycle: got %b expected 11110",
                        {hif.busy, hif.en_pc, hif.en_exmem, hif.en_memwb, hif.flush_memwb});
                end
            end
            advance();
        end
        clearIn();
        #2;
        checks++;
        if (hif.busy !== 1'b0) begin
            errors++; $display("FAIL mem_wait_done: got busy=%b expected 0", hif.busy);
        end
        advance();
    endtask

    task automatic test_timeout();
        hif.mem_req = 1; hif.mem_pc = 32'h0040_1234;
        for (int i = 1; i <= TO; i++) begin
            #2;
            checks++;
            if ({hif.bus_err, (hif.pc_sel == 2'd2)} !== {2{i == TO}}) begin
                errors++; $display("FAIL timeout_cycle%0d: got bus_err=%b pc_sel=%0d expected bus_err=%0d",
                    i, hif.bus_err, hif.pc_sel, (i == TO));
            end
            advance();
        end
        clearIn();
        #2;
        checks++;
        if ({hif.epc, hif.busy} !== {32'h0040_1234, 1'b0}) begin
            errors++; $display("FAIL timeout_after: got epc=%h busy=%b expected epc=00401234 busy=0", hif.epc, hif.busy);
        end
        advance();
    endtask

    task automatic test_exc_eret();
        hif.exc_req = 1; hif.mem_pc = 32'h8000_0104;
        #2;
        checks++;
        if ({hif.flush_ifid, hif.flush_idex, hif.flush_exmem, hif.flush_memwb, hif.redirect_pc} !== {4'hf, 32'h8000_0180}) begin
            errors++; $display("FAIL exception_flush: got fl=%b%b%b%b pc=%h expected fl=1111 pc=80000180",
                hif.flush_ifid, hif.flush_idex, hif.flush_exmem, hif.flush_memwb, hif.redirect_pc);
        end
        advance();
        clearIn();
        #2;
        checks++;
        if (hif.epc !== 32'h8000_0104) begin
            errors++; $display("FAIL exception_epc: got %h expected 80000104", hif.epc);
        end
        advance();
        advance();
        hif.ex_eret = 1;
        #2;
        checks++;
        if ({hif.pc_sel, hif.redirect_pc} !== {2'd3, 32'h8000_0104}) begin
            errors++; $display("FAIL eret_redirect: got sel=%0d pc=%h expected sel=3 pc=80000104", hif.pc_sel, hif.redirect_pc);
        end
        advance();
        clearIn();
    endtask

    task automatic test_async_reset();
        outs_t got;
        hif.mem_req = 1;
        advance();
        advance();
        #2;
        reset = 1'b1;
        #1;
        got = dutOut();
        checks++;
        if (got !== resetOut()) begin
            errors++; $display("FAIL async_reset_outputs: got %h expected %h", got, resetOut());
        end
        #3;
        reset = 1'b0;
        mWaitCycles = 0;
        mEpc = 32'd0;
        clearIn();
        #1;
        checks++;
        if ({hif.epc, hif.busy, hif.en_pc} !== {32'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL async_reset_release: got epc=%h busy=%b en_pc=%b expected epc=0 busy=0 en_pc=1",
                hif.epc, hif.busy, hif.en_pc);
        end
        @(posedge clk);
        #1;
        hif.mem_req = 1;
        for (int i = 1; i <= TO; i++) begin
            #2;
            checks++;
            if (hif.bus_err !== (i == TO)) begin
                errors++; $display("FAIL counter_cleared_cycle%0d: got bus_err=%b expected %0d", i, hif.bus_err, (i == TO));
            end
            advance();
        end
        clearIn();
        advance();
    endtask

    task automatic test_random();
        outs_t got;
        outs_t exp;
        int    ackDiv;
        ackDiv = 2;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) ackDiv = (ackDiv == 2) ? 40 : 2;
            hif.id_rs           = 5'($urandom_range(0, 3));
            hif.id_rt           = 5'($urandom_range(0, 3));
            hif.ex_memread      = ($urandom_range(0, 2) == 0);
            hif.ex_wraddr       = 5'($urandom_range(0, 3));
            hif.ex_branch_taken = ($urandom_range(0, 4) == 0);
            hif.ex_target       = $urandom;
            hif.ex_eret         = ($urandom_range(0, 9) == 0);
            hif.mem_req         = ($urandom_range(0, 3) == 0);
            hif.mem_ack         = ($urandom_range(0, ackDiv - 1) == 0);
            hif.mem_pc          = $urandom;
            hif.exc_req         = ($urandom_range(0, 59) == 0);
            #2;
            got = dutOut();
            exp = modelOut();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random_outputs cycle %0d: got %h expected %h", i, got, exp);
            end
            checks++;
            if (hif.epc !== mEpc) begin
                errors++; $display("FAIL random_epc cycle %0d: got %h expected %h", i, hif.epc, mEpc);
            end
            advance();
        end
        clearIn();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mWaitCycles = 0;
        mEpc = 32'd0;
        reset = 1'b1;
        clearIn();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_exc_eret();
        test_async_reset();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
